// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer and MTHI/MTLO router for HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays sequential.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        hi_ena,
  output logic        lo_ena,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        done,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, WRITE} state_t;
  state_t state, state_nx;
  logic [4:0]  cnt;
  logic        is_div, sa, sb, dz;
  logic [31:0] mb, ma_in, mb_in;
  logic [63:0] prod, prod_ld;
  logic [32:0] sum, rem_sh, diff;
  logic        ge, div_by_zero, fast;
  assign ma_in = (op[0] && a[31]) ? -a : a;
  assign mb_in = (op[0] && b[31]) ? -b : b;
  assign div_by_zero = op[1] && (b == 32'd0);
  assign sum = {1'b0, prod[63:32]} + {1'b0, mb};
  assign rem_sh = prod[63:31];
  assign ge = rem_sh >= {1'b0, mb};
  assign diff = rem_sh - {1'b0, mb};
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fp;
  assign fp = {32'b0, ma_in} * {32'b0, mb_in};
  assign fast = !op[1];
  assign prod_ld = fast ? ((op[0] && (a[31] ^ b[31])) ? -fp : fp) : {32'b0, ma_in};
`else
  assign fast = 1'b0;
  assign prod_ld = {32'b0, ma_in};
`endif
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Multiply keeps {acc, multiplier}; divide keeps {remainder, dividend/quotient} in the same register.
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 5'd0;
      is_div <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      mb <= 32'd0;
      prod <= 64'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt <= 5'd31;
          is_div <= op[1];
          sa <= op[0] & a[31];
          sb <= op[0] & b[31];
          dz <= div_by_zero;
          mb <= mb_in;
          prod <= prod_ld;
        end
        CALC: begin
          cnt <= cnt - 5'd1;
          prod <= is_div ? {ge ? diff[31:0] : rem_sh[31:0], prod[30:0], ge}
                         : {prod[0] ? sum : {1'b0, prod[63:32]}, prod[31:1]};
        end
        FIX: prod <= is_div ? {sa ? -prod[63:32] : prod[63:32], (sa ^ sb) ? -prod[31:0] : prod[31:0]}
                            : ((sa ^ sb) ? -prod : prod);
        default: dz <= dz;
      endcase
    end
  always_comb begin
    state_nx = state;
    busy = 1'b0;
    hi_ena = 1'b0;
    lo_ena = 1'b0;
    hi_wdata = 32'd0;
    lo_wdata = 32'd0;
    done = 1'b0;
    div_zero = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (div_by_zero || fast) ? WRITE : CALC;
      CALC: if (cnt == 5'd0) state_nx = FIX;
      FIX: state_nx = WRITE;
      default: state_nx = IDLE;
    endcase
    if (rst_n) begin
      busy = (state == IDLE && start) || state == CALC || state == FIX;
      done = state == WRITE;
      div_zero = done && dz;
      hi_ena = done ? !dz : (state == IDLE && !start && mthi);
      lo_ena = done ? !dz : (state == IDLE && !start && mtlo);
      hi_wdata = done ? prod[63:32] : wdata;
      lo_wdata = done ? prod[31:0] : wdata;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed self-checking bench for the HI/LO multiply/divide sequencer.
module tb_hilo_muldiv_ctrl;
  logic clk, rst_n, start, mthi, mtlo;
  logic [1:0] op;
  logic [31:0] a, b, wdata;
  logic busy, hi_ena, lo_ena, done, div_zero;
  logic [31:0] hi_wdata, lo_wdata;
  int n_cmp = 0, n_err = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_W = 1;
`else
  localparam int MUL_W = 34;
`endif

  hilo_muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .hi_ena(hi_ena),
    .lo_ena(lo_ena), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .done(done),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Holds start through the whole operation (including WRITE), captures the WRITE cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, y, output int wc, nb,
                        output logic [31:0] h, l, output logic he, le, dzv);
    wc = -1; nb = 0; h = 0; l = 0; he = 0; le = 0; dzv = 0;
    start = 1'b1; op = o; a = x; b = y;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy) nb++;
      if (done && wc < 0) begin
        wc = c; h = hi_wdata; l = lo_wdata; he = hi_ena; le = lo_ena; dzv = div_zero;
      end
      step;
      if (wc >= 0) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFFFFFF;
    #2;
    n_cmp++; if ({busy, hi_ena, lo_ena, done, div_zero} !== 5'b0) begin n_err++; $display("FAIL reset_ctl: got %b expected 00000", {busy, hi_ena, lo_ena, done, div_zero}); end
    n_cmp++; if ({hi_wdata, lo_wdata} !== 64'd0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {hi_wdata, lo_wdata}); end
    step;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rst_n = 1'b1;
    step;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    step;
  endtask

  task automatic test_multu;
    int wc, nb; logic [31:0] h, l; logic he, le, dzv;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, wc, nb, h, l, he, le, dzv);
    n_cmp++; if (wc !== MUL_W) begin n_err++; $display("FAIL multu_write_cycle: got %0d expected %0d", wc, MUL_W); end
    n_cmp++; if (nb !== MUL_W) begin n_err++; $display("FAIL multu_stalls: got %0d expected %0d", nb, MUL_W); end
    n_cmp++; if ({h, l} !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL multu_result: got %h expected fffffffe00000001", {h, l}); end
    n_cmp++; if ({he, le, dzv} !== 3'b110) begin n_err++; $display("FAIL multu_enables: got %b expected 110", {he, le, dzv}); end
    run_op(2'b00, 32'h12345678, 32'h10, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'h00000001_23456780) begin n_err++; $display("FAIL multu_small: got %h expected 0000000123456780", {h, l}); end
  endtask

  task automatic test_mult;
    int wc, nb; logic [31:0] h, l; logic he, le, dzv;
    run_op(2'b01, -32'sd3, 32'd7, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFEB) begin n_err++; $display("FAIL mult_neg: got %h expected ffffffffffffffeb", {h, l}); end
    n_cmp++; if (wc !== MUL_W) begin n_err++; $display("FAIL mult_write_cycle: got %0d expected %0d", wc, MUL_W); end
  endtask

  task automatic test_div;
    int wc, nb; logic [31:0] h, l; logic he, le, dzv;
    run_op(2'b11, -32'sd7, 32'd2, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL div_m7_2: got %h expected fffffffffffffffd", {h, l}); end
    n_cmp++; if (wc !== 34 || nb !== 34) begin n_err++; $display("FAIL div_timing: got %0d/%0d expected 34/34", wc, nb); end
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'h00000000_80000000) begin n_err++; $display("FAIL div_min_m1: got %h expected 0000000080000000", {h, l}); end
    run_op(2'b11, 32'd7, -32'sd2, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'h00000001_FFFFFFFD) begin n_err++; $display("FAIL div_7_m2: got %h expected 00000001fffffffd", {h, l}); end
    run_op(2'b10, 32'hFFFFFFFF, 32'h10, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'h0000000F_0FFFFFFF) begin n_err++; $display("FAIL divu_big: got %h expected 0000000f0fffffff", {h, l}); end
  endtask

  task automatic test_div_zero;
    int wc, nb; logic [31:0] h, l; logic he, le, dzv;
    run_op(2'b10, 32'd100, 32'd0, wc, nb, h, l, he, le, dzv);
    n_cmp++; if (wc !== 1) begin n_err++; $display("FAIL dz_write_cycle: got %0d expected 1", wc); end
    n_cmp++; if (nb !== 1) begin n_err++; $display("FAIL dz_stalls: got %0d expected 1", nb); end
    n_cmp++; if ({he, le, dzv} !== 3'b001) begin n_err++; $display("FAIL dz_flags: got %b expected 001", {he, le, dzv}); end
    #1;
    n_cmp++; if ({div_zero, done} !== 2'b00) begin n_err++; $display("FAIL dz_pulse: got %b expected 00", {div_zero, done}); end
    step;
  endtask

  task automatic test_hold_start;
    int wc, nb, writes; logic [31:0] h, l; logic he, le, dzv;
    run_op(2'b10, 32'd50, 32'd7, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'h00000001_00000007) begin n_err++; $display("FAIL hold_result: got %h expected 0000000100000007", {h, l}); end
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_no_restart: got busy=%b expected 0", busy); end
    writes = 0;
    for (int c = 0; c < 40; c++) begin
      step; #1;
      if (done || busy) writes++;
    end
    n_cmp++; if (writes !== 0) begin n_err++; $display("FAIL hold_extra_activity: got %0d expected 0", writes); end
  endtask

  task automatic test_reset_mid;
    int wc, nb; logic [31:0] h, l; logic he, le, dzv;
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    for (int c = 0; c < 10; c++) step;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, hi_ena, lo_ena, done} !== 4'b0) begin n_err++; $display("FAIL midrst_outputs: got %b expected 0000", {busy, hi_ena, lo_ena, done}); end
    start = 1'b0;
    nb = 0;
    for (int c = 0; c < 30; c++) begin
      step; #1;
      if (busy || hi_ena || lo_ena || done) nb++;
    end
    n_cmp++; if (nb !== 0) begin n_err++; $display("FAIL midrst_held: got %0d active cycles expected 0", nb); end
    rst_n = 1'b1;
    step;
    run_op(2'b10, 32'd9, 32'd2, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'h00000001_00000004) begin n_err++; $display("FAIL midrst_divu: got %h expected 0000000100000004", {h, l}); end
  endtask

  task automatic test_mthi_mtlo;
    int wc, nb; logic [31:0] h, l; logic he, le, dzv;
    mthi = 1'b1; wdata = 32'h12345678;
    #1;
    n_cmp++; if ({hi_ena, lo_ena, busy} !== 3'b100) begin n_err++; $display("FAIL mthi_ctl: got %b expected 100", {hi_ena, lo_ena, busy}); end
    n_cmp++; if (hi_wdata !== 32'h12345678) begin n_err++; $display("FAIL mthi_data: got %h expected 12345678", hi_wdata); end
    step;
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'hCAFEF00D;
    #1;
    n_cmp++; if ({hi_ena, lo_ena, lo_wdata} !== {2'b01, 32'hCAFEF00D}) begin n_err++; $display("FAIL mtlo: got %b %h expected 01 cafef00d", {hi_ena, lo_ena}, lo_wdata); end
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    #1;
    n_cmp++; if ({lo_ena, busy} !== 2'b01) begin n_err++; $display("FAIL mtlo_vs_start: got %b expected 01", {lo_ena, busy}); end
    mtlo = 1'b0;
    run_op(2'b00, 32'd3, 32'd5, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'd15 || wc !== MUL_W) begin n_err++; $display("FAIL mtlo_start_mul: got %h at %0d expected 000000000000000f at %0d", {h, l}, wc, MUL_W); end
  endtask

  task automatic test_back_to_back;
    int wc, nb; logic [31:0] h, l; logic he, le, dzv;
    run_op(2'b01, 32'd6, -32'sd6, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFDC) begin n_err++; $display("FAIL b2b_first: got %h expected ffffffffffffffdc", {h, l}); end
    run_op(2'b11, -32'sd20, -32'sd6, wc, nb, h, l, he, le, dzv);
    n_cmp++; if ({h, l} !== 64'hFFFFFFFE_00000003) begin n_err++; $display("FAIL b2b_second: got %h expected fffffffe00000003", {h, l}); end
    n_cmp++; if (wc !== 34) begin n_err++; $display("FAIL b2b_timing: got %0d expected 34", wc); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div_zero;
    test_hold_start;
    test_reset_mid;
    test_mthi_mtlo;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
